// File: rtl/serial_twos_complement_pkg.sv
// serial_twos_complement_pkg: shared state encoding for the bit-serial negator
package serial_twos_complement_pkg;

    typedef enum logic {
        COPY   = 1'b0,
        INVERT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_twos_complement.sv
// serial_twos_complement: LSB-first serial negator, copies up to the first 1 then inverts
module serial_twos_complement
    import serial_twos_complement_pkg::*;
(
    input  logic i,
    input  logic r,
    input  logic t_clk,
    output logic y
);

    // Power-up value keeps y defined before the first word-boundary reset.
    state_t seen_one = COPY;
    state_t seen_one_nxt;

    always_ff @(posedge t_clk) begin
        if (r)
            seen_one <= COPY;
        else
            seen_one <= seen_one_nxt;
    end

    always_comb seen_one_nxt = (seen_one == COPY && i) ? INVERT : seen_one;

    always_comb y = (r || seen_one == COPY) ? i : ~i;

    a_y_known: assert property (@(posedge t_clk) !$isunknown(y));
    a_invert_sticky: assert property (@(posedge t_clk) (!r && seen_one == INVERT) |=> seen_one == INVERT);

endmodule

// File: tb/tb_serial_twos_complement.sv
// tb_serial_twos_complement: scoreboard bench comparing serial output against arithmetic negation
module tb_serial_twos_complement;

    logic t_clk = 1'b0;
    logic r = 1'b0;
    logic i = 1'b0;
    logic y;
    int n_pass = 0;
    int n_chk = 0;
    logic exp_q[$];

    always #5 t_clk = ~t_clk;

    serial_twos_complement dut (
        .i(i),
        .r(r),
        .t_clk(t_clk),
        .y(y)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: y=%b expected %b at %0t", tag, got, exp, $time);
    endtask

    // Drive within the current cycle, push expectation, then sample 1 time unit later.
    task automatic drive(input string tag, input logic rv, input logic iv, input logic ev);
        r = rv;
        i = iv;
        exp_q.push_back(ev);
        #1;
        check(tag, y, exp_q.pop_front());
    endtask

    task automatic cycle(input string tag, input logic rv, input logic iv, input logic ev);
        @(posedge t_clk);
        #1;
        drive(tag, rv, iv, ev);
    endtask

    // Reset cycle (y follows i=0), then n bits LSB first; expected is -v modulo 2^n.
    task automatic word(input string tag, input int n, input logic [15:0] v);
        logic [15:0] neg;
        neg = ~v + 16'd1;
        cycle({tag, "_rst"}, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < n; k++)
            cycle(tag, 1'b0, v[k], neg[k]);
    endtask

    initial begin
        #1;
        check("powerup_t0", y, 1'b0);
        cycle("powerup", 1'b0, 1'b0, 1'b0);
        cycle("powerup", 1'b0, 1'b0, 1'b0);
        word("six", 4, 16'd6);
        word("one", 4, 16'd1);
        word("eight", 4, 16'd8);
        word("zero", 4, 16'd0);
        cycle("zero_stays_copy", 1'b0, 1'b1, 1'b1);
        // Mid-word reset from INVERT.
        cycle("mid_rst", 1'b1, 1'b0, 1'b0);
        cycle("mid_a", 1'b0, 1'b1, 1'b1);
        cycle("mid_b", 1'b0, 1'b1, 1'b0);
        cycle("mid_override", 1'b1, 1'b1, 1'b1);
        cycle("mid_new_copy", 1'b0, 1'b1, 1'b1);
        cycle("mid_new_inv", 1'b0, 1'b0, 1'b1);
        // Now in INVERT: toggle i between edges.
        drive("comb_inv0", 1'b0, 1'b1, 1'b0);
        drive("comb_inv1", 1'b0, 1'b0, 1'b1);
        drive("comb_inv2", 1'b0, 1'b1, 1'b0);
        // Reset held over several edges: y tracks i, including between edges.
        cycle("rst_hold0", 1'b1, 1'b1, 1'b1);
        drive("rst_comb0", 1'b1, 1'b0, 1'b0);
        drive("rst_comb1", 1'b1, 1'b1, 1'b1);
        cycle("rst_hold1", 1'b1, 1'b0, 1'b0);
        cycle("rst_hold2", 1'b1, 1'b1, 1'b1);
        cycle("after_hold", 1'b0, 1'b0, 1'b0);
        cycle("after_hold", 1'b0, 1'b1, 1'b1);
        cycle("after_hold", 1'b0, 1'b1, 1'b0);
        for (int w = 0; w < 20; w++)
            word("rand", int'($urandom_range(3, 16)), 16'($urandom));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
